// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection; ID_EX_STALL_STATS_EN enables the stall counter
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_RegDst,
  input  logic          id_Branch,
  input  logic          id_MemRead,
  input  logic          id_MemtoReg,
  input  logic          id_MemWrite,
  input  logic          id_AluSrc,
  input  logic          id_RegWrite,
  input  logic [1:0]    id_AluOp,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic [5:0]    id_funct,
  input  logic          flush,
  input  logic          hold,
  output logic          ex_valid,
  output logic          ex_RegDst,
  output logic          ex_Branch,
  output logic          ex_MemRead,
  output logic          ex_MemtoReg,
  output logic          ex_MemWrite,
  output logic          ex_AluSrc,
  output logic          ex_RegWrite,
  output logic [1:0]    ex_AluOp,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [5:0]    ex_funct,
  output logic [RW-1:0] ex_wreg,
  output logic          stall,
  output logic [15:0]   stall_cnt
);
  localparam int W = 16 + 4 * DW + 3 * RW;
  logic [W-1:0] d, q;
  logic         use_rt, lu_hazard;
  assign use_rt    = !id_AluSrc || id_MemWrite;
  assign lu_hazard = ex_valid && ex_MemRead && ex_rt != '0 && id_valid &&
                     (ex_rt == id_rs || (use_rt && ex_rt == id_rt));
  assign stall     = lu_hazard || hold;
  // wreg is resolved here so an x RegDst on non-writing instructions never reaches writeback
  assign d = {1'b1, id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_AluSrc,
              id_RegWrite, id_AluOp, id_rdata1, id_rdata2, id_imm, id_pc4, id_rt, id_rd,
              id_RegWrite ? (id_RegDst ? id_rd : id_rt) : {RW{1'b0}}, id_funct};
  assign {ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_AluSrc,
          ex_RegWrite, ex_AluOp, ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_rt, ex_rd,
          ex_wreg, ex_funct} = q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (flush || (!hold && (lu_hazard || !id_valid))) q <= '0;
    else if (!hold) q <= d;
`ifdef ID_EX_STALL_STATS_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (lu_hazard && !hold && !flush && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign stall_cnt = cnt;
`else
  assign stall_cnt = 16'h0000;
`endif
endmodule
